// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and transmit FSM encoding.
package uart_pkg;

  localparam logic [2:0] TxdataOffset = 3'h0;
  localparam logic [2:0] StatusOffset = 3'h4;

  localparam int unsigned StatusBusyBit     = 0;
  localparam int unsigned StatusFullBit     = 1;
  localparam int unsigned StatusEmptyBit    = 2;
  localparam int unsigned StatusOverflowBit = 3;
  localparam int unsigned StatusLevelLsb    = 4;
  localparam int unsigned StatusLevelWidth  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LevelW = $clog2(Depth) + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LevelW'(Depth));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// busy/full/empty/sticky overflow/level, and a four-state FSM serialises bytes.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  logic win_sel, txdata_sel, status_sel;
  assign win_sel    = (address[31:3] == BASE_ADDR[31:3]);
  assign txdata_sel = win_sel && (address[2] == TxdataOffset[2]);
  assign status_sel = win_sel && (address[2] == StatusOffset[2]);

  logic unused_bits;
  assign unused_bits = ^{address[1:0], wdata[31:8]};

  tx_state_e         state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic              push, pop, full, empty;
  logic [7:0]        fifo_head;
  logic [LevelW-1:0] level;

  assign push = we && txdata_sel;
  assign pop  = (state_q == StIdle) && !empty;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata[7:0]),
    .rdata  (fifo_head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Set is applied after clear so a simultaneous drop keeps overflow high.
  always_comb begin
    overflow_d = overflow_q;
    if (we && status_sel && wdata[StatusOverflowBit]) overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  logic              baud_done;
  logic [BaudW-1:0]  baud_next;
  assign baud_done = (baud_q == BaudLast);
  assign baud_next = baud_done ? '0 : baud_q + 1'b1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shift_d = fifo_head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        baud_d = baud_next;
        if (baud_done) state_d = StData;
      end
      StData: begin
        baud_d = baud_next;
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        baud_d = baud_next;
        if (baud_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is derived from the next state so the line changes on the same edge
  // as the state register, with no decode glitches reaching the pin.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  logic [StatusLevelWidth-1:0] level_field;
  logic [31:0]                 status_word;
  assign level_field = StatusLevelWidth'(level);

  always_comb begin
    status_word                                       = '0;
    status_word[StatusBusyBit]                        = (state_q != StIdle);
    status_word[StatusFullBit]                        = full;
    status_word[StatusEmptyBit]                       = empty;
    status_word[StatusOverflowBit]                    = overflow_q;
    status_word[StatusLevelLsb +: StatusLevelWidth]   = level_field;
  end

  assign rdata = status_sel ? status_word : 32'h0;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected bytes, a serial
// monitor decodes every frame on tx and compares against the queue.
module tb_uart_tx_mmio;

  localparam logic [31:0] ATx     = 32'h1000_0000;
  localparam logic [31:0] AStatus = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        tx;

  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  uart_tx_mmio #(
    .BASE_ADDR    (32'h1000_0000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .address (address),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    wdata   = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
    address = 32'h0;
    wdata   = 32'h0;
  endtask

  // One write per cycle, back to back, bytes taken LSB first.
  task automatic write_burst(input logic [31:0] a, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      address = a;
      wdata   = {24'h0, bytes[8*i +: 8]};
      we      = 1'b1;
    end
    @(negedge clk);
    we      = 1'b0;
    address = 32'h0;
    wdata   = 32'h0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    address = AStatus;
    #1;
    while ((exp_q.size() != 0 || rdata[0]) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain_within_budget", 32'(k < budget), 32'd1);
  endtask

  // Serial monitor: 40 samples per frame at 4 clocks per bit.
  logic [39:0] mon_s;
  logic [7:0]  mon_byte;
  logic [3:0]  mon_nib;
  logic        mon_ok;
  bit          mon_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_s     = '1;
        mon_s[0]  = tx;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (resetn !== 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[k] = tx;
        end
        if (!mon_abort) begin
          mon_ok = (mon_s[3:0] == 4'h0) && (mon_s[39:36] == 4'hF);
          for (int b = 0; b < 8; b++) begin
            mon_nib = mon_s[4 + 4*b +: 4];
            if (mon_nib != 4'h0 && mon_nib != 4'hF) mon_ok = 1'b0;
            mon_byte[b] = mon_nib[0];
          end
          check("frame_format", 32'(mon_ok), 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", mon_byte);
          end else begin
            check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int first_busy;
    int busy_cnt;
    int low_cnt;
    logic tx_first;

    resetn  = 1'b0;
    we      = 1'b0;
    address = 32'h0;
    wdata   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("tx_in_reset", 32'(tx), 32'd1);
    read_check("status_in_reset", AStatus, 32'h0000_0004);
    @(negedge clk);
    resetn = 1'b1;

    // Reset state after release.
    read_check("status_after_reset", AStatus, 32'h0000_0004);
    check("tx_after_reset", 32'(tx), 32'd1);
    read_check("txdata_reads_zero", ATx, 32'h0);

    // Single 0x55 frame: latency and busy duration.
    exp_q.push_back(8'h55);
    bus_write(ATx, 32'h55);
    address    = AStatus;
    first_busy = -1;
    busy_cnt   = 0;
    tx_first   = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (rdata[0]) begin
        busy_cnt++;
        if (first_busy < 0) begin
          first_busy = k;
          tx_first   = tx;
        end
      end
      @(negedge clk);
    end
    check("busy_first_cycle", 32'(first_busy), 32'd1);
    check("tx_low_at_pop", 32'(tx_first), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'd40);
    wait_drain(200);
    read_check("status_idle_1", AStatus, 32'h0000_0004);

    // Six back-to-back pushes: 0x06 is dropped, overflow set.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h05);
    write_burst(ATx, 64'h0000_0605_0403_0201, 6);
    read_check("status_overflow", AStatus, 32'h0000_004B);
    bus_write(AStatus, 32'h8);
    read_check("status_ovf_cleared", AStatus, 32'h0000_0043);
    wait_drain(400);
    read_check("status_idle_2", AStatus, 32'h0000_0004);

    // Reset during DATA bit 3 of 0xA5 with two bytes still queued.
    exp_q.push_back(8'hA5);
    write_burst(ATx, 64'h0000_0000_0077_3CA5, 3);
    repeat (16) @(negedge clk);
    address = AStatus;
    #1;
    check("tx_before_reset", 32'(tx), 32'd0);
    #1;
    resetn = 1'b0;
    #1;
    check("tx_async_reset", 32'(tx), 32'd1);
    check("status_async_reset", rdata, 32'h0000_0004);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn  = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("no_frame_after_reset", 32'(low_cnt), 32'd0);
    read_check("status_after_abort", AStatus, 32'h0000_0004);

    // Unselected write has no effect; TXDATA and out-of-window reads are zero.
    bus_write(32'h1000_0010, 32'h99);
    read_check("read_unselected", 32'h1000_0010, 32'h0);
    read_check("read_txdata", ATx, 32'h0);
    read_check("status_unselected_wr", AStatus, 32'h0000_0004);

    // Low address bits are ignored for both read and write decode.
    read_check("status_alias", 32'h1000_0007, 32'h0000_0004);
    exp_q.push_back(8'hC3);
    bus_write(32'h1000_0002, 32'hFFFF_FFC3);
    wait_drain(200);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    read_check("status_final", AStatus, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
